// File: rtl/aes_cmd_decode_pipe_pkg.sv
// Shared encodings for the AES command decoder: command codes, instruction
// bit positions, register-window offsets and the interlock state type.
package aes_cmd_pkg;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  localparam int NUM_INSTR = 10;

  localparam int IDX_WRITE_ADDRESS = 0;
  localparam int IDX_START_ENCRYPT = 1;
  localparam int IDX_READ_LENGTH   = 2;
  localparam int IDX_READ_ADDRESS  = 3;
  localparam int IDX_READ_KEY      = 4;
  localparam int IDX_READ_COUNTER  = 5;
  localparam int IDX_GET_STATUS    = 6;
  localparam int IDX_WRITE_LENGTH  = 7;
  localparam int IDX_WRITE_KEY     = 8;
  localparam int IDX_WRITE_COUNTER = 9;

  localparam logic [7:0] OFF_START     = 8'h00;
  localparam logic [7:0] OFF_STATUS_LO = 8'h00;
  localparam logic [7:0] OFF_STATUS_HI = 8'h01;
  localparam logic [7:0] OFF_ADDR_LO   = 8'h02;
  localparam logic [7:0] OFF_ADDR_HI   = 8'h03;
  localparam logic [7:0] OFF_LEN_LO    = 8'h04;
  localparam logic [7:0] OFF_LEN_HI    = 8'h05;
  localparam logic [7:0] OFF_KEY_LO    = 8'h10;
  localparam logic [7:0] OFF_KEY_HI    = 8'h1F;
  localparam logic [7:0] OFF_CNTR_LO   = 8'h20;
  localparam logic [7:0] OFF_CNTR_HI   = 8'h2F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic in_range(input logic [7:0] off,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (off >= lo) && (off <= hi);
  endfunction

endpackage

// File: rtl/aes_cmd_decode_pipe_match.sv
// Combinational address/command matcher: maps one host command onto the
// one-hot instruction vector and classifies it as NOP or illegal.
module aes_cmd_match
  import aes_cmd_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter int              DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00
) (
  input  logic [1:0]           cmd,
  input  logic [ADDR_W-1:0]    cmdaddr,
  input  logic [DATA_W-1:0]    cmddata,
  output logic [NUM_INSTR-1:0] onehot,
  output logic                 is_illegal,
  output logic                 is_nop
);

  logic [ADDR_W-1:0]    off_s;
  logic [7:0]           off_lo_s;
  logic                 in_win_s;
  logic                 start_data_s;
  logic [NUM_INSTR-1:0] onehot_s;

  // Offsets above 0xFF can never hit a register, so only the low byte is compared
  assign off_s        = cmdaddr - BASE_ADDR;
  assign off_lo_s     = off_s[7:0];
  assign in_win_s     = (cmdaddr >= BASE_ADDR) && ((off_s >> 4'd8) == {ADDR_W{1'b0}});
  assign start_data_s = (cmddata == {{(DATA_W-1){1'b0}}, 1'b1});

  // Range decode; ranges are disjoint so at most one bit is set
  always_comb begin
    onehot_s = {NUM_INSTR{1'b0}};
    case (cmd)
      CMD_READ: begin
        if (!in_win_s) onehot_s = {NUM_INSTR{1'b0}};
        else if (in_range(off_lo_s, OFF_STATUS_LO, OFF_STATUS_HI)) onehot_s[IDX_GET_STATUS] = 1'b1;
        else if (in_range(off_lo_s, OFF_ADDR_LO, OFF_ADDR_HI)) onehot_s[IDX_READ_ADDRESS] = 1'b1;
        else if (in_range(off_lo_s, OFF_LEN_LO, OFF_LEN_HI)) onehot_s[IDX_READ_LENGTH] = 1'b1;
        else if (in_range(off_lo_s, OFF_KEY_LO, OFF_KEY_HI)) onehot_s[IDX_READ_KEY] = 1'b1;
        else if (in_range(off_lo_s, OFF_CNTR_LO, OFF_CNTR_HI)) onehot_s[IDX_READ_COUNTER] = 1'b1;
        else onehot_s = {NUM_INSTR{1'b0}};
      end
      CMD_WRITE: begin
        if (!in_win_s) onehot_s = {NUM_INSTR{1'b0}};
        else if ((off_lo_s == OFF_START) && start_data_s) onehot_s[IDX_START_ENCRYPT] = 1'b1;
        else if (in_range(off_lo_s, OFF_ADDR_LO, OFF_ADDR_HI)) onehot_s[IDX_WRITE_ADDRESS] = 1'b1;
        else if (in_range(off_lo_s, OFF_LEN_LO, OFF_LEN_HI)) onehot_s[IDX_WRITE_LENGTH] = 1'b1;
        else if (in_range(off_lo_s, OFF_KEY_LO, OFF_KEY_HI)) onehot_s[IDX_WRITE_KEY] = 1'b1;
        else if (in_range(off_lo_s, OFF_CNTR_LO, OFF_CNTR_HI)) onehot_s[IDX_WRITE_COUNTER] = 1'b1;
        else onehot_s = {NUM_INSTR{1'b0}};
      end
      default: onehot_s = {NUM_INSTR{1'b0}};
    endcase
  end

  assign onehot     = onehot_s;
  assign is_nop     = (cmd == CMD_NOP);
  assign is_illegal = (cmd != CMD_NOP) && (onehot_s == {NUM_INSTR{1'b0}});

endmodule

// File: rtl/aes_cmd_decode_pipe.sv
// Registered AES command decoder with one-entry output register and encrypt
// interlock. Define AES_DECODE_ILLEGAL_CNT_EN to build the illegal-command counter.
module aes_cmd_decode_pipe
  import aes_cmd_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00,
  parameter int                CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           cmd,
  input  logic [ADDR_W-1:0]    cmdaddr,
  input  logic [DATA_W-1:0]    cmddata,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [NUM_INSTR-1:0] instr_onehot,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic                 illegal,
  input  logic                 enc_done,
  output logic                 busy,
  output logic [CNT_W-1:0]     illegal_cnt
);

  logic [NUM_INSTR-1:0] match_onehot_s;
  logic                 match_illegal_s;
  logic                 match_nop_s;
  logic [NUM_INSTR-1:0] onehot_r;
  logic                 instr_valid_r;
  logic                 illegal_r;
  logic                 busy_r;
  state_t               state_r;
  logic                 write_stall_s;
  logic                 accept_s;
  logic                 out_fire_s;
  logic                 load_s;

  aes_cmd_match #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_match (
    .cmd        (cmd),
    .cmdaddr    (cmdaddr),
    .cmddata    (cmddata),
    .onehot     (match_onehot_s),
    .is_illegal (match_illegal_s),
    .is_nop     (match_nop_s)
  );

  assign write_stall_s = (state_r == ST_BUSY) && (cmd == CMD_WRITE);
  assign cmd_ready     = (!instr_valid_r || instr_ready) && !write_stall_s;
  assign accept_s      = cmd_valid && cmd_ready;
  assign out_fire_s    = instr_valid_r && instr_ready;
  assign load_s        = accept_s && !match_nop_s && !match_illegal_s;

  // One-entry output register; onehot is cleared whenever the entry is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onehot_r      <= {NUM_INSTR{1'b0}};
      instr_valid_r <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      if (load_s) begin
        onehot_r      <= match_onehot_s;
        instr_valid_r <= 1'b1;
      end else if (out_fire_s) begin
        onehot_r      <= {NUM_INSTR{1'b0}};
        instr_valid_r <= 1'b0;
      end else begin
        onehot_r      <= onehot_r;
        instr_valid_r <= instr_valid_r;
      end
      illegal_r <= accept_s && match_illegal_s;
    end
  end

  // Encrypt interlock: busy from START_ENCRYPT leaving the register until enc_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (out_fire_s && onehot_r[IDX_START_ENCRYPT]) begin
            state_r <= ST_BUSY;
            busy_r  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (enc_done) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_DECODE_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating illegal-command counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s && match_illegal_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign illegal_cnt = cnt_r;
`else
  assign illegal_cnt = {CNT_W{1'b0}};
`endif

  assign instr_onehot = onehot_r;
  assign instr_valid  = instr_valid_r;
  assign illegal      = illegal_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_aes_cmd_decode_pipe.sv
// Directed self-checking bench for aes_cmd_decode_pipe; a second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_aes_cmd_decode_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd = 2'd0;
  logic [15:0] cmdaddr = 16'h0000;
  logic [7:0]  cmddata = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        instr_ready = 1'b1;
  logic        enc_done = 1'b0;

  logic        cmd_ready;
  logic [9:0]  instr_onehot;
  logic        instr_valid;
  logic        illegal;
  logic        busy;
  logic [7:0]  illegal_cnt;

  logic        cmd_ready2;
  logic [9:0]  instr_onehot2;
  logic        instr_valid2;
  logic        illegal2;
  logic        busy2;
  logic [1:0]  illegal_cnt2;

  int checks = 0;
  int failures = 0;

`ifdef AES_DECODE_ILLEGAL_CNT_EN
  localparam logic [7:0] EXP_CNT4 = 8'd4;
  localparam logic [7:0] EXP_CNT5 = 8'd5;
  localparam logic [1:0] EXP_SAT  = 2'd3;
`else
  localparam logic [7:0] EXP_CNT4 = 8'd0;
  localparam logic [7:0] EXP_CNT5 = 8'd0;
  localparam logic [1:0] EXP_SAT  = 2'd0;
`endif

  aes_cmd_decode_pipe dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmdaddr(cmdaddr), .cmddata(cmddata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .instr_onehot(instr_onehot),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .illegal(illegal),
    .enc_done(enc_done), .busy(busy), .illegal_cnt(illegal_cnt)
  );

  aes_cmd_decode_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cmd(cmd), .cmdaddr(cmdaddr), .cmddata(cmddata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .instr_onehot(instr_onehot2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready), .illegal(illegal2),
    .enc_done(enc_done), .busy(busy2), .illegal_cnt(illegal_cnt2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [15:0] a, input logic [7:0] d);
    cmd = c; cmdaddr = a; cmddata = d; cmd_valid = 1'b1;
  endtask

  task automatic idle();
    cmd = 2'd0; cmdaddr = 16'h0000; cmddata = 8'h00; cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr_onehot !== 10'h000) begin failures++; $display("FAIL reset_onehot got=%h exp=000", instr_onehot); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (illegal_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_addr();
    instr_ready = 1'b1;
    drive(2'd2, 16'hFF02, 8'h5A);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL waddr_ready0 got=%b exp=1", cmd_ready); end
    tick(); idle();
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL waddr_valid got=%b exp=1", instr_valid); end
    checks++; if (instr_onehot !== 10'h001) begin failures++; $display("FAIL waddr_onehot got=%h exp=001", instr_onehot); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL waddr_ready1 got=%b exp=1", cmd_ready); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL waddr_drain got=%b exp=0", instr_valid); end
    checks++; if (instr_onehot !== 10'h000) begin failures++; $display("FAIL waddr_zero got=%h exp=000", instr_onehot); end
  endtask

  task automatic test_back_to_back();
    drive(2'd1, 16'hFF00, 8'h00);
    tick();
    drive(2'd1, 16'hFF20, 8'h00);
    checks++; if (instr_onehot !== 10'h040) begin failures++; $display("FAIL b2b_status got=%h exp=040", instr_onehot); end
    tick(); idle();
    checks++; if (instr_onehot !== 10'h020 || instr_valid !== 1'b1) begin failures++; $display("FAIL b2b_counter got=%h/%b exp=020/1", instr_onehot, instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", instr_valid); end
  endtask

  localparam logic [1:0]  T_CMD  [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
  localparam logic [15:0] T_ADDR [9] = '{16'hFF01, 16'hFF03, 16'hFF05, 16'hFF1F, 16'hFF2F,
                                         16'hFF03, 16'hFF04, 16'hFF10, 16'hFF2F};
  localparam logic [9:0]  T_EXP  [9] = '{10'h040, 10'h008, 10'h004, 10'h010, 10'h020,
                                         10'h001, 10'h080, 10'h100, 10'h200};

  task automatic test_ranges();
    for (int i = 0; i < 9; i++) begin
      drive(T_CMD[i], T_ADDR[i], 8'hA5);
      tick();
      checks++;
      if (instr_onehot !== T_EXP[i] || instr_valid !== 1'b1) begin
        failures++; $display("FAIL range_%0d got=%h/%b exp=%h/1", i, instr_onehot, instr_valid, T_EXP[i]);
      end
    end
    idle();
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL range_drain got=%b exp=0", instr_valid); end
  endtask

  task automatic test_encrypt_interlock();
    drive(2'd2, 16'hFF00, 8'h01);
    tick(); idle();
    checks++; if (instr_onehot !== 10'h002 || busy !== 1'b0) begin failures++; $display("FAIL enc_start got=%h/%b exp=002/0", instr_onehot, busy); end
    tick();
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL enc_busy got=%b/%b exp=1/0", busy, instr_valid); end
    drive(2'd2, 16'hFF10, 8'h33);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL enc_wstall got=%b exp=0", cmd_ready); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL enc_wnotacc got=%b exp=0", instr_valid); end
    drive(2'd1, 16'hFF10, 8'h00);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL enc_rready got=%b exp=1", cmd_ready); end
    tick();
    checks++; if (instr_onehot !== 10'h010) begin failures++; $display("FAIL enc_readkey got=%h exp=010", instr_onehot); end
    drive(2'd2, 16'hFF10, 8'h33);
    enc_done = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL enc_donestall got=%b exp=0", cmd_ready); end
    tick();
    enc_done = 1'b0;
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL enc_idle got=%b/%b exp=0/0", busy, instr_valid); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL enc_wready got=%b exp=1", cmd_ready); end
    tick(); idle();
    checks++; if (instr_onehot !== 10'h100 || instr_valid !== 1'b1) begin failures++; $display("FAIL enc_wkey got=%h/%b exp=100/1", instr_onehot, instr_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    drive(2'd1, 16'hFF04, 8'h00);
    tick();
    drive(2'd1, 16'hFF02, 8'h00);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_onehot !== 10'h004 || instr_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold_%0d got=%h/%b exp=004/1", i, instr_onehot, instr_valid);
      end
      tick();
    end
    instr_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", cmd_ready); end
    tick(); idle();
    checks++; if (instr_onehot !== 10'h008) begin failures++; $display("FAIL bp_next got=%h exp=008", instr_onehot); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", instr_valid); end
  endtask

  localparam logic [1:0]  I_CMD  [5] = '{2'd2, 2'd1, 2'd3, 2'd1, 2'd2};
  localparam logic [15:0] I_ADDR [5] = '{16'hFF00, 16'hFF06, 16'hFF00, 16'h00FF, 16'hFF30};
  localparam logic [7:0]  I_DATA [5] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01};

  task automatic test_illegal();
    for (int i = 0; i < 5; i++) begin
      drive(I_CMD[i], I_ADDR[i], I_DATA[i]);
      tick(); idle();
      checks++;
      if (illegal !== 1'b1 || instr_valid !== 1'b0) begin
        failures++; $display("FAIL ill_pulse_%0d got=%b/%b exp=1/0", i, illegal, instr_valid);
      end
      tick();
      checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_clear_%0d got=%b exp=0", i, illegal); end
      if (i == 3) begin
        checks++; if (illegal_cnt !== EXP_CNT4) begin failures++; $display("FAIL ill_cnt4 got=%0d exp=%0d", illegal_cnt, EXP_CNT4); end
      end
    end
    checks++; if (illegal_cnt !== EXP_CNT5) begin failures++; $display("FAIL ill_cnt5 got=%0d exp=%0d", illegal_cnt, EXP_CNT5); end
    checks++; if (illegal_cnt2 !== EXP_SAT) begin failures++; $display("FAIL ill_sat got=%0d exp=%0d", illegal_cnt2, EXP_SAT); end
    drive(2'd0, 16'hFF02, 8'h00);
    tick(); idle();
    checks++; if (illegal !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL nop_drop got=%b/%b exp=0/0", illegal, instr_valid); end
    checks++; if (illegal_cnt !== EXP_CNT5) begin failures++; $display("FAIL nop_cnt got=%0d exp=%0d", illegal_cnt, EXP_CNT5); end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    drive(2'd2, 16'hFF00, 8'h01);
    tick();
    drive(2'd1, 16'hFF00, 8'h00);
    tick(); idle();
    instr_ready = 1'b0;
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b/%b exp=1/1", busy, instr_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL ar_clear got=%b/%b exp=0/0", busy, instr_valid); end
    checks++; if (instr_onehot !== 10'h000 || illegal_cnt !== 8'd0) begin failures++; $display("FAIL ar_regs got=%h/%0d exp=000/0", instr_onehot, illegal_cnt); end
    tick();
    rst = 1'b0;
    instr_ready = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_back_to_back();
    test_ranges();
    test_encrypt_interlock();
    test_backpressure();
    test_illegal();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
